mux_reg_n: RTL and testbench

Parametrised, registered N-channel operand multiplexer for the 16-bit datapath. It generalises the combinational 4-way, 16-bit select to any channel count and width. The output is registered with a valid bit, stall (enable), flush, and a self-sequencing scan mode that steps through every channel for debug and bring-up. It sits between the register file/immediate/PC sources and the ALU operand inputs.

---
 rtl/mux_reg_n.sv | 101 ++++++++++
 tb/tb_mux_reg_n.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux_reg_n.sv
// ============================================================================
//  Module      : mux_reg_n
//  Description : Registered N-channel operand multiplexer with valid, stall,
//                flush, sticky select-error flag and self-sequencing scan mode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_reg_n #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [CHANNELS*WIDTH-1:0] In,
    input  logic [SEL_W-1:0]          s,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      scan,
    input  logic                      in_valid,
    output logic [WIDTH-1:0]          O,
    output logic                      O_valid,
    output logic [SEL_W-1:0]          scan_idx,
    output logic                      sel_err
);

    localparam logic [SEL_W:0]   c_CHANNELS = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] c_LAST     = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] w_ch [CHANNELS];
    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] w_scan_data;
    logic             w_s_ok;

    logic [WIDTH-1:0] r_o;
    logic             r_o_valid;
    logic [SEL_W-1:0] r_scan_idx;
    logic             r_sel_err;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
            assign w_ch[k] = In[k*WIDTH +: WIDTH];
        end
    endgenerate

    // Compare-based muxes keep out-of-range selects from indexing past the array.
    always_comb begin
        w_sel_data  = '0;
        w_scan_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (s == SEL_W'(k)) begin
                w_sel_data = w_ch[k];
            end
            if (r_scan_idx == SEL_W'(k)) begin
                w_scan_data = w_ch[k];
            end
        end
    end

    assign w_s_ok = ({1'b0, s} < c_CHANNELS);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_o        <= '0;
            r_o_valid  <= 1'b0;
            r_scan_idx <= '0;
            r_sel_err  <= 1'b0;
        end else if (flush) begin
            r_o        <= '0;
            r_o_valid  <= 1'b0;
            r_scan_idx <= '0;
        end else if (en) begin
            if (scan) begin
                r_o        <= w_scan_data;
                r_o_valid  <= 1'b1;
                r_scan_idx <= (r_scan_idx == c_LAST) ? '0 : r_scan_idx + 1'b1;
            end else begin
                r_scan_idx <= '0;
                if (w_s_ok) begin
                    r_o       <= w_sel_data;
                    r_o_valid <= in_valid;
                end else begin
                    r_o       <= '0;
                    r_o_valid <= 1'b0;
                    if (in_valid) begin
                        r_sel_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign O        = r_o;
    assign O_valid  = r_o_valid;
    assign scan_idx = r_scan_idx;
    assign sel_err  = r_sel_err;

endmodule

`default_nettype wire

// File: tb/tb_mux_reg_n.sv
// ============================================================================
//  Module      : tb_mux_reg_n
//  Description : Directed-vector bench for mux_reg_n (4-channel and 3-channel).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_reg_n;

    logic        CLK = 1'b0;
    logic        Reset, en, flush, scan, in_valid;
    logic [1:0]  s;
    logic [63:0] In4;
    logic [47:0] In3;

    logic [15:0] O4, O3;
    logic        V4, V3, E4, E3;
    logic [1:0]  I4, I3;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mux_reg_n #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) u_dut4 (
        .CLK(CLK), .Reset(Reset), .In(In4), .s(s), .en(en), .flush(flush),
        .scan(scan), .in_valid(in_valid), .O(O4), .O_valid(V4),
        .scan_idx(I4), .sel_err(E4)
    );

    mux_reg_n #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) u_dut3 (
        .CLK(CLK), .Reset(Reset), .In(In3), .s(s), .en(en), .flush(flush),
        .scan(scan), .in_valid(in_valid), .O(O3), .O_valid(V3),
        .scan_idx(I3), .sel_err(E3)
    );

    typedef struct {
        logic        rst, fl, e, sc, iv;
        logic [1:0]  sel;
        logic [15:0] exp_o;
        logic        exp_v;
        logic [1:0]  exp_idx;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, fl, e, sc, iv, input logic [1:0] sel,
                       input logic [15:0] eo, input logic ev,
                       input logic [1:0] ei, input logic ee);
        vec_t v;
        v.rst = rst; v.fl = fl; v.e = e; v.sc = sc; v.iv = iv; v.sel = sel;
        v.exp_o = eo; v.exp_v = ev; v.exp_idx = ei; v.exp_err = ee;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, fl, e, sc, iv, input logic [1:0] sel);
        Reset = rst; flush = fl; en = e; scan = sc; in_valid = iv; s = sel;
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [15:0] eo, input logic ev,
                        input logic [1:0] ei, input logic ee);
        chk({tag, ".O"}, 32'(O4), 32'(eo));
        chk({tag, ".O_valid"}, 32'(V4), 32'(ev));
        chk({tag, ".scan_idx"}, 32'(I4), 32'(ei));
        chk({tag, ".sel_err"}, 32'(E4), 32'(ee));
    endtask

    task automatic chk3(input string tag, input logic [15:0] eo, input logic ev,
                        input logic [1:0] ei, input logic ee);
        chk({tag, ".O"}, 32'(O3), 32'(eo));
        chk({tag, ".O_valid"}, 32'(V3), 32'(ev));
        chk({tag, ".scan_idx"}, 32'(I3), 32'(ei));
        chk({tag, ".sel_err"}, 32'(E3), 32'(ee));
    endtask

    initial begin
        In4 = {16'd4, 16'd3, 16'd2, 16'd1};
        In3 = {16'd7, 16'd6, 16'd5};
        drive(1, 0, 0, 0, 0, 2'd0);

        //   rst fl en sc iv s    O   V idx err
        add(1, 0, 0, 0, 0, 2'd0, 16'd0, 0, 2'd0, 0);   // reset state
        add(0, 0, 1, 0, 1, 2'd0, 16'd1, 1, 2'd0, 0);   // normal selects
        add(0, 0, 1, 0, 1, 2'd1, 16'd2, 1, 2'd0, 0);
        add(0, 0, 1, 0, 1, 2'd2, 16'd3, 1, 2'd0, 0);
        add(0, 0, 1, 0, 1, 2'd3, 16'd4, 1, 2'd0, 0);
        add(0, 0, 1, 1, 0, 2'd0, 16'd1, 1, 2'd1, 0);   // scan with wrap
        add(0, 0, 1, 1, 0, 2'd0, 16'd2, 1, 2'd2, 0);
        add(0, 0, 1, 1, 0, 2'd0, 16'd3, 1, 2'd3, 0);
        add(0, 0, 1, 1, 0, 2'd0, 16'd4, 1, 2'd0, 0);
        add(0, 0, 1, 1, 0, 2'd0, 16'd1, 1, 2'd1, 0);
        add(0, 0, 1, 1, 0, 2'd0, 16'd2, 1, 2'd2, 0);
        add(0, 0, 0, 1, 0, 2'd0, 16'd2, 1, 2'd2, 0);   // stall mid-scan
        add(0, 0, 0, 1, 0, 2'd0, 16'd2, 1, 2'd2, 0);
        add(0, 0, 1, 1, 0, 2'd0, 16'd3, 1, 2'd3, 0);   // resume
        add(0, 0, 1, 0, 1, 2'd0, 16'd1, 1, 2'd0, 0);   // drop scan
        add(0, 0, 1, 1, 0, 2'd0, 16'd1, 1, 2'd1, 0);
        add(0, 0, 1, 1, 0, 2'd0, 16'd2, 1, 2'd2, 0);
        add(0, 1, 1, 1, 0, 2'd0, 16'd0, 0, 2'd0, 0);   // flush beats scan
        add(0, 0, 1, 1, 0, 2'd0, 16'd1, 1, 2'd1, 0);
        add(0, 0, 1, 1, 0, 2'd0, 16'd2, 1, 2'd2, 0);
        add(1, 0, 1, 1, 0, 2'd0, 16'd0, 0, 2'd0, 0);   // reset mid-scan
        add(0, 0, 1, 1, 0, 2'd0, 16'd1, 1, 2'd1, 0);
        add(0, 0, 1, 0, 0, 2'd1, 16'd2, 0, 2'd0, 0);   // in_valid=0 select
        add(0, 1, 0, 0, 1, 2'd2, 16'd0, 0, 2'd0, 0);   // flush beats stall
        add(0, 0, 0, 0, 1, 2'd2, 16'd0, 0, 2'd0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].fl, tbl[i].e, tbl[i].sc, tbl[i].iv, tbl[i].sel);
            step();
            chk4($sformatf("vec%0d", i), tbl[i].exp_o, tbl[i].exp_v,
                 tbl[i].exp_idx, tbl[i].exp_err);
        end

        // Stall while select and channel data change underneath.
        drive(0, 0, 1, 0, 1, 2'd2);
        step();
        chk4("stall_load", 16'd3, 1, 2'd0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 2'd0);
            In4 = {4{16'hA000 + 16'(i)}};
            step();
            chk4($sformatf("stall%0d", i), 16'd3, 1, 2'd0, 0);
        end
        In4 = {16'd4, 16'd3, 16'd2, 16'd1};

        // Out-of-range select on the 3-channel instance.
        drive(1, 0, 0, 0, 0, 2'd0);
        step();
        chk3("r3_reset", 16'd0, 0, 2'd0, 0);
        drive(0, 0, 1, 0, 0, 2'd3);
        step();
        chk3("oor_novalid", 16'd0, 0, 2'd0, 0);
        drive(0, 0, 1, 0, 1, 2'd3);
        step();
        chk3("oor_valid", 16'd0, 0, 2'd0, 1);
        drive(0, 0, 1, 0, 1, 2'd0);
        step();
        chk3("oor_sticky_sel0", 16'd5, 1, 2'd0, 1);
        drive(0, 1, 1, 0, 1, 2'd0);
        step();
        chk3("oor_sticky_flush", 16'd0, 0, 2'd0, 1);
        drive(0, 0, 1, 0, 1, 2'd2);
        step();
        chk3("oor_sticky_sel2", 16'd7, 1, 2'd0, 1);
        drive(1, 0, 1, 0, 1, 2'd2);
        step();
        chk3("oor_reset_clear", 16'd0, 0, 2'd0, 0);

        // Non-power-of-two scan wrap.
        drive(0, 0, 1, 1, 0, 2'd3);
        step();
        chk3("scan3_0", 16'd5, 1, 2'd1, 0);
        step();
        chk3("scan3_1", 16'd6, 1, 2'd2, 0);
        step();
        chk3("scan3_2", 16'd7, 1, 2'd0, 0);
        step();
        chk3("scan3_3", 16'd5, 1, 2'd1, 0);

        drive(0, 0, 0, 0, 0, 2'd0);
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
